// File: rtl/reaction_stats.sv
// reaction_stats: score keeping for the reaction-time game.
// Captures completed trials, tracks last/best/rolling-4 average and false
// starts, and drives a registered, pageable value to the 7-segment driver.
//
// view | meaning
// -----+------------------------------------------
//  0   | LAST   - most recent captured trial
//  1   | BEST   - fastest trial since clear (0 if none)
//  2   | AVG    - rounded mean of last 4 trials (0 until 4 captured)
//  3   | FAULTS - false-start count, zero-extended
module reaction_stats #(
  parameter int W      = 14,
  parameter int MAX_MS = 9999
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         done,
  input  logic         show_error,
  input  logic [W-1:0] ms_time,
  input  logic         view_btn,
  output logic [W-1:0] disp_value,
  output logic         disp_error,
  output logic [1:0]   view,
  output logic         avg_valid,
  output logic [3:0]   trial_count,
  output logic [3:0]   fault_count,
  output logic         new_best
);

  localparam logic [W-1:0] MAX_V     = W'(MAX_MS);
  localparam logic [1:0]   VIEW_LAST = 2'd0;
  localparam logic [1:0]   VIEW_BEST = 2'd1;
  localparam logic [1:0]   VIEW_AVG  = 2'd2;
  localparam logic [1:0]   VIEW_FLT  = 2'd3;
  localparam logic [3:0]   CNT_MAX   = 4'd15;

  logic           done_q;
  logic           err_q;
  logic           done_rise;
  logic           err_rise;
  logic           capture;
  logic [W-1:0]   sample;
  logic           improve;
  logic           stats_valid;

  logic [W-1:0]   last;
  logic [W-1:0]   best;
  logic [W-1:0]   h0;
  logic [W-1:0]   h1;
  logic [W-1:0]   h2;
  logic [W-1:0]   h3;
  logic [W+1:0]   sum;
  logic [W-1:0]   avg;
  logic [W-1:0]   disp_sel;

  assign done_rise = done & ~done_q;
  assign err_rise  = show_error & ~err_q;
  // A false start on the same edge as a completion discards the trial.
  assign capture   = done_rise & ~err_rise;
  assign sample    = (ms_time > MAX_V) ? MAX_V : ms_time;
  // The first trial after clear always becomes best, whatever its value.
  assign improve   = (trial_count == 4'd0) || (sample < best);
  assign stats_valid = (trial_count >= 4'd4);
  // Half-up rounding of the 4-trial mean; sum never exceeds 4*MAX_MS.
  assign avg       = W'((sum + (W+2)'(2)) >> 2);

  // Edge-detect registers; these keep tracking even during clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done;
      err_q  <= show_error;
    end
  end

  // Trial capture: last, history window, running sum and best.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last     <= '0;
      best     <= MAX_V;
      h0       <= '0;
      h1       <= '0;
      h2       <= '0;
      h3       <= '0;
      sum      <= '0;
      new_best <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (clear) begin
        last <= '0;
        best <= MAX_V;
        h0   <= '0;
        h1   <= '0;
        h2   <= '0;
        h3   <= '0;
        sum  <= '0;
      end else if (capture) begin
        last <= sample;
        h0   <= sample;
        h1   <= h0;
        h2   <= h1;
        h3   <= h2;
        // h3 is the sample leaving the window, so the sum stays a 4-trial sum.
        sum  <= sum + {2'b00, sample} - {2'b00, h3};
        if (improve) begin
          best     <= sample;
          new_best <= 1'b1;
        end
      end
    end
  end

  // Valid-trial counter, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trial_count <= '0;
    end else if (clear) begin
      trial_count <= '0;
    end else if (capture && (trial_count != CNT_MAX)) begin
      trial_count <= trial_count + 4'd1;
    end
  end

  // False-start counter, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_count <= '0;
    end else if (clear) begin
      fault_count <= '0;
    end else if (err_rise && (fault_count != CNT_MAX)) begin
      fault_count <= fault_count + 4'd1;
    end
  end

  // View pager: a finished trial snaps back to LAST, beating the button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      view <= VIEW_LAST;
    end else if (clear || done_rise) begin
      view <= VIEW_LAST;
    end else if (view_btn) begin
      view <= view + 2'd1;
    end
  end

  // Select the value for the current view from the committed stats.
  always_comb begin
    disp_sel = '0;
    case (view)
      VIEW_LAST: disp_sel = last;
      VIEW_BEST: disp_sel = (trial_count == 4'd0) ? '0 : best;
      VIEW_AVG:  disp_sel = stats_valid ? avg : '0;
      VIEW_FLT:  disp_sel = {{(W-4){1'b0}}, fault_count};
      default:   disp_sel = '0;
    endcase
  end

  // Registered display outputs, one cycle behind the stats they show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_value <= '0;
      avg_valid  <= 1'b0;
      disp_error <= 1'b0;
    end else begin
      disp_value <= disp_sel;
      avg_valid  <= stats_valid;
      disp_error <= err_q;
    end
  end

endmodule

// File: tb/tb_reaction_stats.sv
// tb_reaction_stats: directed plus randomized checks of reaction_stats
// against a trial-list reference model.
module tb_reaction_stats;

  localparam int W      = 14;
  localparam int MAX_MS = 9999;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         done = 1'b0;
  logic         show_error = 1'b0;
  logic [W-1:0] ms_time = '0;
  logic         view_btn = 1'b0;
  logic [W-1:0] disp_value;
  logic         disp_error;
  logic [1:0]   view;
  logic         avg_valid;
  logic [3:0]   trial_count;
  logic [3:0]   fault_count;
  logic         new_best;

  always #5 clk = ~clk;

  reaction_stats #(.W(W), .MAX_MS(MAX_MS)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .done       (done),
    .show_error (show_error),
    .ms_time    (ms_time),
    .view_btn   (view_btn),
    .disp_value (disp_value),
    .disp_error (disp_error),
    .view       (view),
    .avg_valid  (avg_valid),
    .trial_count(trial_count),
    .fault_count(fault_count),
    .new_best   (new_best)
  );

  int n_pass = 0;
  int n_checks = 0;

  // Reference model: list of trials since clear (newest first), plus pager.
  int hist[$];
  int m_last, m_best, m_trials, m_faults, m_view;
  bit m_doneq, m_errq;
  int o_disp;
  bit o_derr, o_avgv, o_nb;

  function automatic int m_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return (s + 2) / 4;
  endfunction

  function automatic int m_dispval();
    case (m_view)
      0: return m_last;
      1: return (m_trials == 0) ? 0 : m_best;
      2: return (m_trials >= 4) ? m_avg() : 0;
      default: return m_faults;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    m_last = 0; m_best = MAX_MS; m_trials = 0; m_faults = 0; m_view = 0;
    m_doneq = 0; m_errq = 0;
    o_disp = 0; o_derr = 0; o_avgv = 0; o_nb = 0;
  endtask

  task automatic model_edge();
    bit dr, er;
    int s;
    dr = done & ~m_doneq;
    er = show_error & ~m_errq;
    o_disp = m_dispval();
    o_avgv = (m_trials >= 4);
    o_derr = m_errq;
    o_nb = 0;
    if (clear) begin
      hist.delete();
      m_last = 0; m_best = MAX_MS; m_trials = 0; m_faults = 0; m_view = 0;
    end else begin
      if (er) begin
        if (m_faults < 15) m_faults++;
      end else if (dr) begin
        s = (int'(ms_time) > MAX_MS) ? MAX_MS : int'(ms_time);
        m_last = s;
        hist.push_front(s);
        if (hist.size() > 4) void'(hist.pop_back());
        if (m_trials == 0 || s < m_best) begin
          m_best = s;
          o_nb = 1;
        end
        if (m_trials < 15) m_trials++;
      end
      if (dr) m_view = 0;
      else if (view_btn) m_view = (m_view + 1) % 4;
    end
    m_doneq = done;
    m_errq = show_error;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    check("disp_value",  32'(disp_value),  32'(o_disp));
    check("disp_error",  32'(disp_error),  32'(o_derr));
    check("view",        32'(view),        32'(m_view));
    check("avg_valid",   32'(avg_valid),   32'(o_avgv));
    check("trial_count", 32'(trial_count), 32'(m_trials));
    check("fault_count", 32'(fault_count), 32'(m_faults));
    check("new_best",    32'(new_best),    32'(o_nb));
  endtask

  // One clock: advance the model with the current inputs, then check.
  task automatic cycle();
    if (!reset) model_edge();
    @(posedge clk);
    #1;
    view_btn = 1'b0;
    clear = 1'b0;
    check_all();
  endtask

  task automatic trial(input int ms, input int hold);
    done = 1'b1;
    ms_time = W'(ms);
    cycle();
    for (int i = 1; i < hold; i++) begin
      ms_time = W'($urandom_range(0, 16383));
      cycle();
    end
    done = 1'b0;
    cycle();
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      view_btn = 1'b1;
      cycle();
    end
  endtask

  int view_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
    cycle();

    // Basic four-trial run; holds and mid-hold ms_time changes must be ignored.
    trial(300, 1);
    trial(250, 3);
    trial(400, 1);
    trial(250, 2);
    check("trial_count_4", 32'(trial_count), 32'd4);
    press(2);
    cycle();
    check("avg_300", 32'(disp_value), 32'd300);
    check("avg_valid_4", 32'(avg_valid), 32'd1);

    // Pager walk from LAST.
    press(2);
    for (int i = 0; i < 5; i++) begin
      view_btn = 1'b1;
      cycle();
      check("view_seq", 32'(view), 32'(view_seq[i]));
    end
    cycle();
    check("best_250", 32'(disp_value), 32'd250);

    // Fifth trial slides the window.
    trial(500, 1);
    press(2);
    cycle();
    check("avg_350", 32'(disp_value), 32'd350);

    // False start coincident with completion.
    show_error = 1'b1;
    done = 1'b1;
    ms_time = W'(100);
    cycle();
    cycle();
    check("disp_error_2cyc", 32'(disp_error), 32'd1);
    check("trial_count_err", 32'(trial_count), 32'd5);
    show_error = 1'b0;
    done = 1'b0;
    cycle();
    press(3);
    cycle();
    check("faults_view", 32'(disp_value), 32'd1);

    // Button coincident with a completion.
    press(1);
    view_btn = 1'b1;
    done = 1'b1;
    ms_time = W'(600);
    cycle();
    check("btn_vs_done", 32'(view), 32'd0);
    done = 1'b0;
    cycle();

    // Clear coincident with a completion.
    press(2);
    clear = 1'b1;
    done = 1'b1;
    ms_time = W'(50);
    cycle();
    check("clear_trials", 32'(trial_count), 32'd0);
    check("clear_new_best", 32'(new_best), 32'd0);
    check("clear_view", 32'(view), 32'd0);
    done = 1'b0;
    press(1);
    cycle();
    check("best_after_clear", 32'(disp_value), 32'd0);

    // Clamp on the first trial after clear.
    trial(16383, 1);
    check("clamp_last", 32'(disp_value), 32'd9999);
    press(1);
    cycle();
    check("clamp_best", 32'(disp_value), 32'd9999);

    // Randomized play.
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 11);
      if (kind == 0) begin
        clear = 1'b1;
        cycle();
      end else if (kind == 1) begin
        show_error = 1'b1;
        done = $urandom_range(0, 1);
        ms_time = W'($urandom_range(0, 16383));
        cycle();
        show_error = 1'b0;
        done = 1'b0;
        cycle();
      end else if (kind <= 3) begin
        press($urandom_range(1, 4));
        cycle();
      end else begin
        view_btn = $urandom_range(0, 1);
        trial($urandom_range(80, 12000), $urandom_range(1, 3));
        view_btn = $urandom_range(0, 1);
        cycle();
      end
    end
    press(2);
    cycle();

    // Async reset mid-run with done held; capture on the first clock after release.
    done = 1'b1;
    ms_time = W'(777);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    reset = 1'b0;
    cycle();
    check("post_reset_capture", 32'(trial_count), 32'd1);
    done = 1'b0;
    cycle();
    check("post_reset_last", 32'(disp_value), 32'd777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
